// File: rtl/mbf_param.sv
// mbf_param: streams a frame of QW-bit ROM words and assembles them MSB-first
// into DW-bit samples. Each sample feeds a TAPS-deep moving-average low-pass
// output y and a complementary, mid-scale-offset high-pass output z.
//
// Handshake: start is a one-cycle request and is accepted only while busy is
// low (IDLE). busy stays high from the cycle after acceptance until the frame
// ends. done pulses for exactly one cycle in that last busy cycle. y_valid and
// z_valid are single-cycle strobes with no backpressure. The ROM read is a
// fixed-latency read: rom_q carries data one cycle after rom_a is presented
// with rom_cen low.
module mbf_param #(
    parameter int QW = 4,
    parameter int DW = 8,
    parameter int AW = 10,
    parameter int LT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [QW-1:0] rom_q,
    output logic [AW-1:0] rom_a,
    output logic          rom_cen,
    output logic          y_valid,
    output logic [DW-1:0] y,
    output logic          z_valid,
    output logic [DW-1:0] z,
    output logic          busy,
    output logic          done
);

    localparam int R    = DW / QW;
    localparam int TAPS = 1 << LT;
    localparam int GW   = (R > 1) ? $clog2(R) : 1;
    localparam int ACW  = DW + LT;

    localparam logic [AW:0]           LAST_ADDR = {1'b0, {AW{1'b1}}};
    localparam logic signed [DW+1:0]  MID       = {3'b001, {(DW-1){1'b0}}};
    localparam logic signed [DW+1:0]  MAXV      = {2'b00, {DW{1'b1}}};

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t state, state_nx;

    logic [AW:0]     addr;          // one spare bit so the terminal address never wraps
    logic            rd_vld;        // rom_q carries a requested word this cycle
    logic [1:0]      mode_q;
    logic [GW-1:0]   grp;           // word position within the current sample
    logic [DW-1:0]   shift_q;       // partially assembled sample
    logic [DW-1:0]   hist [TAPS];   // hist[0] is the newest sample
    logic [ACW-1:0]  acc;           // running sum of hist
    logic [LT:0]     fill;

    logic                   accept;
    logic [DW-1:0]          x_c;
    logic                   sample_done;
    logic [LT:0]            fill_nx;
    logic                   full;
    logic [ACW-1:0]         sum_c;
    logic [DW-1:0]          y_c;
    logic signed [DW+1:0]   d_c;
    logic [DW-1:0]          z_c;

    // Sample assembly, moving-average and high-pass arithmetic
    always_comb begin
        accept      = (state == IDLE) && start;
        x_c         = DW'({shift_q, rom_q});
        sample_done = rd_vld && (grp == GW'(R - 1));
        fill_nx     = (fill == (LT+1)'(TAPS)) ? fill : fill + 1'b1;
        full        = (fill_nx == (LT+1)'(TAPS));
        sum_c       = acc + ACW'(x_c) - ACW'(hist[TAPS-1]);
        y_c         = DW'(sum_c >> LT);
        d_c         = $signed({2'b00, x_c}) - $signed({2'b00, y_c}) + MID;
        if (d_c < 0)
            z_c = '0;
        else if (d_c > MAXV)
            z_c = '1;
        else
            z_c = d_c[DW-1:0];
    end

    // Next-state and control outputs
    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = (state == DONE);
        rom_cen  = (state != FETCH);
        rom_a    = (state == FETCH) ? addr[AW-1:0] : '0;
        case (state)
            IDLE:    if (start) state_nx = FETCH;
            FETCH:   if (addr == LAST_ADDR) state_nx = DRAIN;
            DRAIN:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Address counter, read-valid tracking and mode latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr   <= '0;
            rd_vld <= 1'b0;
            mode_q <= 2'b00;
        end else begin
            rd_vld <= (state == FETCH);
            if (accept) begin
                addr   <= '0;
                mode_q <= mode;
            end else if (state == FETCH) begin
                addr   <= addr + 1'b1;
            end
        end
    end

    // Assembly, history and accumulator; all cleared at the start of a frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grp     <= '0;
            shift_q <= '0;
            acc     <= '0;
            fill    <= '0;
            for (int i = 0; i < TAPS; i++) hist[i] <= '0;
        end else if (accept) begin
            grp     <= '0;
            shift_q <= '0;
            acc     <= '0;
            fill    <= '0;
            for (int i = 0; i < TAPS; i++) hist[i] <= '0;
        end else if (rd_vld) begin
            shift_q <= x_c;
            grp     <= sample_done ? '0 : grp + 1'b1;
            if (sample_done) begin
                for (int i = TAPS-1; i > 0; i--) hist[i] <= hist[i-1];
                hist[0] <= x_c;
                acc     <= sum_c;
                fill    <= fill_nx;
            end
        end
    end

    // Registered outputs; strobes gated by the mode latched at start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_valid <= 1'b0;
            z_valid <= 1'b0;
            y       <= '0;
            z       <= '0;
        end else begin
            y_valid <= sample_done && full && mode_q[0];
            z_valid <= sample_done && full && mode_q[1];
            if (sample_done && full) begin
                y <= y_c;
                z <= z_c;
            end
        end
    end

endmodule

// File: tb/tb_mbf_param.sv
// Bench for mbf_param: a ROM model, a frame-level reference model built from
// the ROM contents, and per-scenario tasks with inline checks.
module tb_mbf_param;

    localparam int QW   = 4;
    localparam int DW   = 8;
    localparam int AW   = 10;
    localparam int LT   = 2;
    localparam int R    = DW / QW;
    localparam int TAPS = 1 << LT;
    localparam int NW   = 1 << AW;
    localparam int S    = NW / R;

    logic          clk;
    logic          reset;
    logic          start;
    logic [1:0]    mode;
    logic [QW-1:0] rom_q;
    logic [AW-1:0] rom_a;
    logic          rom_cen;
    logic          y_valid;
    logic [DW-1:0] y;
    logic          z_valid;
    logic [DW-1:0] z;
    logic          busy;
    logic          done;

    int n_checks;
    int n_fail;

    logic [QW-1:0] rom_mem [NW];

    // scoreboard: expected strobe cycle and values, in frame order
    int            exp_t_q[$];
    logic [DW-1:0] exp_y_q[$];
    logic [DW-1:0] exp_z_q[$];

    mbf_param #(.QW(QW), .DW(DW), .AW(AW), .LT(LT)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .rom_q   (rom_q),
        .rom_a   (rom_a),
        .rom_cen (rom_cen),
        .y_valid (y_valid),
        .y       (y),
        .z_valid (z_valid),
        .z       (z),
        .busy    (busy),
        .done    (done)
    );

    // clock and synchronous ROM
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rom_cen) rom_q <= rom_mem[rom_a];
    end

    // Reference model: build samples from ROM words, then a TAPS-point average
    // and an offset difference clamped to the output range.
    task automatic build_model();
        int xs [S];
        exp_t_q.delete();
        exp_y_q.delete();
        exp_z_q.delete();
        for (int k = 0; k < S; k++) begin
            int x;
            x = 0;
            for (int j = 0; j < R; j++) x = x * (1 << QW) + int'(rom_mem[k*R + j]);
            xs[k] = x;
        end
        for (int k = TAPS - 1; k < S; k++) begin
            int s, yv, zv;
            s = 0;
            for (int j = 0; j < TAPS; j++) s += xs[k - j];
            yv = s / TAPS;
            zv = xs[k] - yv + (1 << (DW - 1));
            if (zv < 0) zv = 0;
            if (zv > (1 << DW) - 1) zv = (1 << DW) - 1;
            exp_t_q.push_back(k * R + R - 1 + 2);
            exp_y_q.push_back(DW'(yv));
            exp_z_q.push_back(DW'(zv));
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NW; i++) rom_mem[i] = QW'($urandom_range(0, (1 << QW) - 1));
    endtask

    task automatic fill_samples_pattern(input int p0, input int p1, input int p2, input int p3);
        int pat [4];
        pat[0] = p0; pat[1] = p1; pat[2] = p2; pat[3] = p3;
        for (int k = 0; k < S; k++)
            for (int j = 0; j < R; j++)
                rom_mem[k*R + j] = QW'((pat[k % 4] >> (QW * (R - 1 - j))) & ((1 << QW) - 1));
    endtask

    // Run one full frame from start, checking every cycle against the model.
    // n counts rising edges after the edge that accepts start.
    task automatic run_frame(input logic [1:0] m, input int extra_start, input string tag);
        int n_y, n_z, n_done, want_strobes;
        build_model();
        want_strobes = exp_t_q.size();
        n_y = 0; n_z = 0; n_done = 0;
        @(posedge clk); #1;
        mode  = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = 2'($urandom_range(0, 3));
        for (int n = 0; n <= NW + 6; n++) begin
            logic          e_cen, e_busy, e_done, strobe, e_yv, e_zv;
            logic [AW-1:0] e_a;
            e_cen  = !(n <= NW - 1);
            e_a    = (n <= NW - 1) ? AW'(n) : '0;
            e_busy = (n <= NW + 1);
            e_done = (n == NW + 1);
            strobe = (exp_t_q.size() > 0) && (exp_t_q[0] == n);
            e_yv   = strobe && m[0];
            e_zv   = strobe && m[1];
            n_checks++;
            if (rom_cen !== e_cen) begin
                n_fail++;
                $display("FAIL %s rom_cen n=%0d got %b want %b", tag, n, rom_cen, e_cen);
            end
            n_checks++;
            if (rom_a !== e_a) begin
                n_fail++;
                $display("FAIL %s rom_a n=%0d got %0d want %0d", tag, n, rom_a, e_a);
            end
            n_checks++;
            if (busy !== e_busy) begin
                n_fail++;
                $display("FAIL %s busy n=%0d got %b want %b", tag, n, busy, e_busy);
            end
            n_checks++;
            if (done !== e_done) begin
                n_fail++;
                $display("FAIL %s done n=%0d got %b want %b", tag, n, done, e_done);
            end
            n_checks++;
            if (y_valid !== e_yv) begin
                n_fail++;
                $display("FAIL %s y_valid n=%0d got %b want %b", tag, n, y_valid, e_yv);
            end
            n_checks++;
            if (z_valid !== e_zv) begin
                n_fail++;
                $display("FAIL %s z_valid n=%0d got %b want %b", tag, n, z_valid, e_zv);
            end
            if (y_valid === 1'b1) n_y++;
            if (z_valid === 1'b1) n_z++;
            if (done === 1'b1) n_done++;
            if (strobe) begin
                if (m[0]) begin
                    n_checks++;
                    if (y !== exp_y_q[0]) begin
                        n_fail++;
                        $display("FAIL %s y n=%0d got %h want %h", tag, n, y, exp_y_q[0]);
                    end
                end
                if (m[1]) begin
                    n_checks++;
                    if (z !== exp_z_q[0]) begin
                        n_fail++;
                        $display("FAIL %s z n=%0d got %h want %h", tag, n, z, exp_z_q[0]);
                    end
                end
                void'(exp_t_q.pop_front());
                void'(exp_y_q.pop_front());
                void'(exp_z_q.pop_front());
            end
            start = (n == extra_start) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_checks++;
        if (n_y !== (m[0] ? S - TAPS + 1 : 0)) begin
            n_fail++;
            $display("FAIL %s y_strobe_count got %0d want %0d", tag, n_y, m[0] ? S - TAPS + 1 : 0);
        end
        n_checks++;
        if (n_z !== (m[1] ? want_strobes : 0)) begin
            n_fail++;
            $display("FAIL %s z_strobe_count got %0d want %0d", tag, n_z, m[1] ? want_strobes : 0);
        end
        n_checks++;
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL %s done_count got %0d want 1", tag, n_done);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if ({rom_cen, busy, done, y_valid, z_valid} !== 5'b10000) begin
            n_fail++;
            $display("FAIL %s ctrl got %b want 10000", tag, {rom_cen, busy, done, y_valid, z_valid});
        end
        n_checks++;
        if ({rom_a, y, z} !== '0) begin
            n_fail++;
            $display("FAIL %s data rom_a=%0d y=%h z=%h want all 0", tag, rom_a, y, z);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        mode  = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < NW; i++) rom_mem[i] = QW'(1);
        run_frame(2'b11, -1, "all_ones");
    endtask

    task automatic test_step();
        for (int i = 0; i < NW; i++) rom_mem[i] = (i < NW / 2) ? QW'(0) : QW'((1 << QW) - 1);
        run_frame(2'b11, -1, "step");
    endtask

    task automatic test_ramp_down();
        fill_samples_pattern(255, 255, 255, 0);
        run_frame(2'b11, -1, "ramp_down");
    endtask

    task automatic test_modes();
        fill_random();
        run_frame(2'b01, -1, "mode01");
        fill_random();
        run_frame(2'b10, -1, "mode10");
        fill_random();
        run_frame(2'b00, -1, "mode00");
    endtask

    task automatic test_start_ignored();
        fill_random();
        run_frame(2'b11, 100, "start_ignored");
    endtask

    task automatic test_reset_mid_frame();
        fill_random();
        @(posedge clk); #1;
        mode  = 2'b11;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (rom_a !== AW'(300)) begin
            n_fail++;
            $display("FAIL abort rom_a_before got %0d want 300", rom_a);
        end
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({busy, done} !== 2'b00) begin
                n_fail++;
                $display("FAIL abort hold busy/done got %b want 00", {busy, done});
            end
        end
        reset = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({busy, done, rom_cen} !== 3'b001) begin
                n_fail++;
                $display("FAIL abort wait busy/done/cen got %b want 001", {busy, done, rom_cen});
            end
        end
        run_frame(2'b11, -1, "after_abort");
    endtask

    task automatic test_back_to_back();
        fill_random();
        run_frame(2'b11, -1, "b2b_first");
        fill_random();
        run_frame(2'b11, -1, "b2b_second");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        start    = 1'b0;
        mode     = 2'b00;
        test_reset();
        test_all_ones();
        test_step();
        test_ramp_down();
        test_modes();
        test_start_ignored();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
